data_mem_arbiter: RTL and testbench

Two-port arbiter sharing the single-port data memory (`dataMemory`/`genericRAM`, one read/write port, registered read address) between the CPU load/store path and a loader/debug requester. It grants one access per cycle using a burst-limited round-robin policy. It drives the memory address, write data and write enable, and returns read data to the winning requester one cycle after its grant. It sits between the datapath's memory stage and `dataMemory`.

---
 rtl/data_mem_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_data_mem_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// ============================================================================
// data_mem_arbiter
//
// Shares the single-port data memory (dataMemory / genericRAM: one read/write
// port, registered read address) between the CPU load/store path (C) and the
// loader/debug requester (L). One access is granted per cycle using a
// burst-limited round-robin policy. Grants are combinational in the request
// cycle. The transfer commits at the following rising edge. Read data is
// returned to the winner one cycle after its grant.
//
// Parameters
//   dataW   data word width
//   addrW   word address width (matches dataMemory)
//   BURST   max consecutive grants to one port while the other is requesting
//
// Ports
//   sysCLK, sysRST          clock; synchronous active-high reset
//   reqC/wrC/addrC/wdataC   CPU request, 1 = write, word address, write data
//   gntC                    CPU access accepted this cycle
//   rvalidC/rdataC          CPU read data valid / read data (0 when not valid)
//   reqL ... rdataL         same set for the loader/debug port
//   memAddr/memDataW/memRW  to memory addr / dataIN / enWR
//   memDataR                from memory Q
// ============================================================================
module data_mem_arbiter #(
    parameter int unsigned dataW = 32,
    parameter int unsigned addrW = 16,
    parameter int unsigned BURST = 4
) (
    input  logic             sysCLK,
    input  logic             sysRST,

    input  logic             reqC,
    input  logic             wrC,
    input  logic [addrW-1:0] addrC,
    input  logic [dataW-1:0] wdataC,
    output logic             gntC,
    output logic             rvalidC,
    output logic [dataW-1:0] rdataC,

    input  logic             reqL,
    input  logic             wrL,
    input  logic [addrW-1:0] addrL,
    input  logic [dataW-1:0] wdataL,
    output logic             gntL,
    output logic             rvalidL,
    output logic [dataW-1:0] rdataL,

    output logic [addrW-1:0] memAddr,
    output logic [dataW-1:0] memDataW,
    output logic             memRW,
    input  logic [dataW-1:0] memDataR
);

    // Arbiter states: which port (if any) was granted in the previous cycle.
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] OWN_C = 2'd1;
    localparam logic [1:0] OWN_L = 2'd2;

    // lastSrv encoding
    localparam logic SRV_C = 1'b0;
    localparam logic SRV_L = 1'b1;

    // beats counts 0..BURST inclusive
    localparam int unsigned   beatW   = $clog2(BURST + 1);
    localparam logic [beatW-1:0] beatMax = beatW'(BURST);
    localparam logic [beatW-1:0] beatOne = beatW'(1);

    logic [1:0]       state;
    logic [1:0]       stateNext;
    logic             lastSrv;
    logic             lastSrvNext;
    logic [beatW-1:0] beats;
    logic [beatW-1:0] beatsNext;
    logic [beatW-1:0] beatsInc;
    logic             burstLeft;

    logic             pickC;
    logic             pickL;

    logic             rvalidCQ;
    logic             rvalidLQ;

    assign burstLeft = (beats < beatMax);
    assign beatsInc  = (beats == beatMax) ? beatMax : beats + beatOne;

    // ------------------------------------------------------------------
    // Grant decision
    // ------------------------------------------------------------------
    always_comb begin
        pickC = 1'b0;
        pickL = 1'b0;
        case (state)
            OWN_C: begin
                // Owner keeps the port until its burst is spent, unless the
                // other side is not asking at all.
                if (reqC && (burstLeft || !reqL)) begin
                    pickC = 1'b1;
                end else if (reqL) begin
                    pickL = 1'b1;
                end
            end
            OWN_L: begin
                if (reqL && (burstLeft || !reqC)) begin
                    pickL = 1'b1;
                end else if (reqC) begin
                    pickC = 1'b1;
                end
            end
            default: begin
                if (reqC && reqL) begin
                    // Tie from idle: serve whoever was not served last.
                    if (lastSrv == SRV_L) begin
                        pickC = 1'b1;
                    end else begin
                        pickL = 1'b1;
                    end
                end else begin
                    pickC = reqC;
                    pickL = reqL;
                end
            end
        endcase
    end

    // Grants are suppressed while reset is held so nothing is committed.
    assign gntC = pickC & ~sysRST;
    assign gntL = pickL & ~sysRST;

    // ------------------------------------------------------------------
    // Next-state
    // ------------------------------------------------------------------
    always_comb begin
        stateNext   = IDLE;
        lastSrvNext = lastSrv;
        beatsNext   = '0;
        if (gntC) begin
            stateNext   = OWN_C;
            lastSrvNext = SRV_C;
            beatsNext   = (state == OWN_C) ? beatsInc : beatOne;
        end else if (gntL) begin
            stateNext   = OWN_L;
            lastSrvNext = SRV_L;
            beatsNext   = (state == OWN_L) ? beatsInc : beatOne;
        end
    end

    always_ff @(posedge sysCLK) begin
        if (sysRST) begin
            state    <= IDLE;
            lastSrv  <= SRV_L;
            beats    <= '0;
            rvalidCQ <= 1'b0;
            rvalidLQ <= 1'b0;
        end else begin
            state    <= stateNext;
            lastSrv  <= lastSrvNext;
            beats    <= beatsNext;
            rvalidCQ <= gntC & ~wrC;
            rvalidLQ <= gntL & ~wrL;
        end
    end

    // ------------------------------------------------------------------
    // Memory drive
    // ------------------------------------------------------------------
    always_comb begin
        memAddr  = '0;
        memDataW = '0;
        memRW    = 1'b0;
        if (gntC) begin
            memAddr  = addrC;
            memDataW = wdataC;
            memRW    = wrC;
        end else if (gntL) begin
            memAddr  = addrL;
            memDataW = wdataL;
            memRW    = wrL;
        end
    end

    // ------------------------------------------------------------------
    // Read return
    // ------------------------------------------------------------------
    // A read granted the cycle before reset is dropped: the registered flag
    // is still set during the reset cycle, so it is masked here as well.
    assign rvalidC = rvalidCQ & ~sysRST;
    assign rvalidL = rvalidLQ & ~sysRST;
    assign rdataC  = rvalidC ? memDataR : '0;
    assign rdataL  = rvalidL ? memDataR : '0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
module tb_data_mem_arbiter;

    localparam int BURST = 4;

    logic        sysCLK;
    logic        sysRST;
    logic        reqC, wrC, gntC, rvalidC;
    logic [15:0] addrC;
    logic [31:0] wdataC, rdataC;
    logic        reqL, wrL, gntL, rvalidL;
    logic [15:0] addrL;
    logic [31:0] wdataL, rdataL;
    logic [15:0] memAddr;
    logic [31:0] memDataW, memDataR;
    logic        memRW;

    data_mem_arbiter #(.dataW(32), .addrW(16), .BURST(BURST)) dut (
        .sysCLK(sysCLK), .sysRST(sysRST),
        .reqC(reqC), .wrC(wrC), .addrC(addrC), .wdataC(wdataC),
        .gntC(gntC), .rvalidC(rvalidC), .rdataC(rdataC),
        .reqL(reqL), .wrL(wrL), .addrL(addrL), .wdataL(wdataL),
        .gntL(gntL), .rvalidL(rvalidL), .rdataL(rdataL),
        .memAddr(memAddr), .memDataW(memDataW), .memRW(memRW),
        .memDataR(memDataR)
    );

    initial sysCLK = 1'b0;
    always #5 sysCLK = ~sysCLK;

    // Single-port memory with registered read address
    logic [31:0] memArr [0:65535];
    logic [15:0] memAddrQ;
    always @(posedge sysCLK) begin
        if (memRW) memArr[memAddr] <= memDataW;
        memAddrQ <= memAddr;
    end
    assign memDataR = memArr[memAddrQ];

    typedef struct {
        logic        rst;
        logic        rc;
        logic        wc;
        logic [15:0] ac;
        logic [31:0] dc;
        logic        rl;
        logic        wl;
        logic [15:0] al;
        logic [31:0] dl;
        logic        gc;
        logic        gl;
    } vec_t;

    vec_t tbl[$];
    int   nVec = 0;
    int   nErr = 0;

    logic [31:0] refMem [logic [15:0]];
    logic [31:0] qC[$];
    logic [31:0] qL[$];

    function automatic vec_t mk(input logic rst,
                                input logic rc, input logic wc, input logic [15:0] ac, input logic [31:0] dc,
                                input logic rl, input logic wl, input logic [15:0] al, input logic [31:0] dl,
                                input logic gc, input logic gl);
        vec_t v;
        v.rst = rst; v.rc = rc; v.wc = wc; v.ac = ac; v.dc = dc;
        v.rl = rl; v.wl = wl; v.al = al; v.dl = dl; v.gc = gc; v.gl = gl;
        return v;
    endfunction

    function automatic vec_t idle(input logic rst);
        return mk(rst, 0, 0, 16'h0, 32'h0, 0, 0, 16'h0, 32'h0, 0, 0);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] refRead(input logic [15:0] a);
        if (refMem.exists(a)) return refMem[a];
        return 32'h0;
    endfunction

    // Scoreboard step, called once per cycle just before the rising edge
    task automatic sbStep();
        logic        expV;
        logic [31:0] expD;
        expV = (qC.size() > 0) && !sysRST;
        chk("rvalidC", {31'b0, rvalidC}, {31'b0, expV});
        if (expV) begin
            expD = qC.pop_front();
            chk("rdataC", rdataC, expD);
        end else begin
            chk("rdataC idle", rdataC, 32'h0);
        end
        if (sysRST) qC.delete();

        expV = (qL.size() > 0) && !sysRST;
        chk("rvalidL", {31'b0, rvalidL}, {31'b0, expV});
        if (expV) begin
            expD = qL.pop_front();
            chk("rdataL", rdataL, expD);
        end else begin
            chk("rdataL idle", rdataL, 32'h0);
        end
        if (sysRST) qL.delete();

        chk("gntExcl", {31'b0, gntC & gntL}, 32'h0);

        if (gntC) begin
            if (wrC) refMem[addrC] = wdataC;
            else     qC.push_back(refRead(addrC));
        end
        if (gntL) begin
            if (wrL) refMem[addrL] = wdataL;
            else     qL.push_back(refRead(addrL));
        end
    endtask

    task automatic applyVec(input vec_t v);
        logic        eRW;
        logic [15:0] eAddr;
        logic [31:0] eData;
        @(negedge sysCLK);
        sysRST = v.rst;
        reqC = v.rc; wrC = v.wc; addrC = v.ac; wdataC = v.dc;
        reqL = v.rl; wrL = v.wl; addrL = v.al; wdataL = v.dl;
        #4;
        eRW   = v.gc ? v.wc : (v.gl ? v.wl : 1'b0);
        eAddr = v.gc ? v.ac : (v.gl ? v.al : 16'h0);
        eData = v.gc ? v.dc : (v.gl ? v.dl : 32'h0);
        chk("gntC", {31'b0, gntC}, {31'b0, v.gc});
        chk("gntL", {31'b0, gntL}, {31'b0, v.gl});
        chk("memRW", {31'b0, memRW}, {31'b0, eRW});
        chk("memAddr", {16'b0, memAddr}, {16'b0, eAddr});
        chk("memDataW", memDataW, eData);
        sbStep();
    endtask

    initial begin
        logic doneC, doneL;
        int   waitC, waitL;

        sysRST = 1'b1;
        reqC = 0; wrC = 0; addrC = '0; wdataC = '0;
        reqL = 0; wrL = 0; addrL = '0; wdataL = '0;

        // Reset with requests present: no grants, no write
        tbl.push_back(mk(1, 1, 1, 16'h0010, 32'hDEADBEEF, 1, 0, 16'h0000, 32'h0, 0, 0));
        // CPU write then read-back of 0x0010
        tbl.push_back(mk(0, 1, 1, 16'h0010, 32'hDEADBEEF, 0, 0, 16'h0, 32'h0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 16'h0010, 32'h0, 0, 0, 16'h0, 32'h0, 1, 0));
        tbl.push_back(idle(0));
        // Re-reset after C was last served: first tie must still go to C
        tbl.push_back(idle(1));
        for (int i = 0; i < 12; i++)
            tbl.push_back(mk(0, 1, 1, 16'h0020, 32'hCCCC0001, 1, 1, 16'h0030, 32'h11110001,
                             (i < 4 || i >= 8), (i >= 4 && i < 8)));
        tbl.push_back(idle(0));
        // Loader-only burst of 10 writes, then CPU reads 0x0105
        for (int i = 0; i < 10; i++)
            tbl.push_back(mk(0, 0, 0, 16'h0, 32'h0, 1, 1, 16'h0100 + 16'(i), 32'h10000000 + 32'(i), 0, 1));
        tbl.push_back(mk(0, 1, 0, 16'h0105, 32'h0, 0, 0, 16'h0, 32'h0, 1, 0));
        tbl.push_back(idle(0));
        // Loader owns with beats=2 when CPU arrives: two more L grants, then C
        tbl.push_back(mk(0, 0, 0, 16'h0, 32'h0, 1, 0, 16'h0100, 32'h0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 16'h0, 32'h0, 1, 0, 16'h0101, 32'h0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 16'h0105, 32'h0, 1, 0, 16'h0102, 32'h0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 16'h0105, 32'h0, 1, 0, 16'h0103, 32'h0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 16'h0105, 32'h0, 1, 0, 16'h0104, 32'h0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 16'h0, 32'h0, 1, 0, 16'h0104, 32'h0, 0, 1));
        tbl.push_back(idle(0));
        // Loader drops early: CPU granted the same cycle
        tbl.push_back(mk(0, 0, 0, 16'h0, 32'h0, 1, 0, 16'h0106, 32'h0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 16'h0, 32'h0, 1, 0, 16'h0107, 32'h0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 16'h0010, 32'h0, 1, 0, 16'h0108, 32'h0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 16'h0010, 32'h0, 0, 0, 16'h0, 32'h0, 1, 0));
        tbl.push_back(idle(0));
        // L read at N, reset at N+1: read lost; first tie after reset to C
        tbl.push_back(mk(0, 0, 0, 16'h0, 32'h0, 1, 0, 16'h0109, 32'h0, 0, 1));
        tbl.push_back(mk(1, 1, 0, 16'h0105, 32'h0, 1, 0, 16'h0100, 32'h0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 16'h0105, 32'h0, 1, 0, 16'h0100, 32'h0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 16'h0, 32'h0, 1, 0, 16'h0100, 32'h0, 0, 1));
        tbl.push_back(idle(0));
        tbl.push_back(idle(0));

        foreach (tbl[i]) applyVec(tbl[i]);

        // Hand-written: read-after-write on consecutive cycles, different ports
        applyVec(mk(0, 0, 0, 16'h0, 32'h0, 1, 1, 16'h0105, 32'hA5A5A5A5, 0, 1));
        applyVec(mk(0, 1, 0, 16'h0105, 32'h0, 0, 0, 16'h0, 32'h0, 1, 0));
        applyVec(idle(0));
        chk("refMem 0105", refRead(16'h0105), 32'hA5A5A5A5);

        // Random interleaved traffic on 0x0100..0x0109 (all written above)
        doneC = 0; doneL = 0; waitC = 0; waitL = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge sysCLK);
            sysRST = 1'b0;
            if (doneC) reqC = 1'b0;
            if (doneL) reqL = 1'b0;
            if (!reqC && $urandom_range(0, 3) != 0) begin
                reqC = 1'b1; wrC = 1'($urandom_range(0, 1));
                addrC = 16'h0100 + 16'($urandom_range(0, 9)); wdataC = $urandom;
            end
            if (!reqL && $urandom_range(0, 3) != 0) begin
                reqL = 1'b1; wrL = 1'($urandom_range(0, 1));
                addrL = 16'h0100 + 16'($urandom_range(0, 9)); wdataL = $urandom;
            end
            #4;
            sbStep();
            if (reqC) begin
                if (gntC) waitC = 0;
                else begin
                    waitC++;
                    chk("waitC", 32'(waitC > BURST), 32'h0);
                end
            end
            if (reqL) begin
                if (gntL) waitL = 0;
                else begin
                    waitL++;
                    chk("waitL", 32'(waitL > BURST), 32'h0);
                end
            end
            doneC = gntC;
            doneL = gntL;
        end

        // Drain outstanding reads
        applyVec(idle(0));
        applyVec(idle(0));

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
